abs_accumulator: RTL and testbench
==================================

# abs_accumulator

Parametrised magnitude accumulator: sums the absolute value of N_ITER two's-complement input samples into a wider accumulator, under a start/done handshake with per-cycle sample enable. It is the configurable successor of the fixed 32-bit, 99-iteration accumulator. It sits between a sample source and a consumer that reads one result per run. It adds a sticky overflow flag and optional saturation.

## Interface
- DATA_W, 32, input sample width (two's complement), >= 2
- ACC_W, 32, accumulator/result width, must be >= DATA_W
- N_ITER, 99, samples accumulated per run, >= 1
- CNT_W, $clog2(N_ITER+1), derived localparam for the sample counter; not overridable
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a new run (sampled in IDLE or DONE only)
- en  in  1  sample valid; x is accepted on any RUN cycle with en=1
- x  in  DATA_W  input sample, two's complement
- y  out  ACC_W  accumulator value, registered
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when a run completes
- overflow  out  1  sticky; set if any accumulation exceeded 2^ACC_W-1 during the current run

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: start=1 -> clear y, counter and overflow; go to RUN next cycle. start=0 -> hold y and overflow unchanged.
- RUN: busy=1. Each cycle with en=1:
  - y <= y + |x|.
  - |x| = x if x[DATA_W-1]=0, else -x. The most-negative x has magnitude 2^(DATA_W-1), exact, with no sign error.
  - |x| is zero-extended to ACC_W.
  - Counter increments.
- en=0 in RUN: y and counter hold. No timeout.
- When the sample with counter value N_ITER-1 is accepted -> DONE next cycle.
- DONE: lasts exactly one cycle. done=1, busy=0, y holds the final sum.
  - start=1 in DONE: behaves as in IDLE (clear, go to RUN).
  - Otherwise go to IDLE.
- start is ignored while in RUN. There is no abort except rst.
- Overflow: the addition is computed at ACC_W+1 bits. A carry-out sets overflow, which stays set until the next accepted start or rst. Result handling depends on the configuration macro.
- y, overflow remain readable in IDLE until the next start.

## Timing
- Reset values: y=0, busy=0, done=0, overflow=0, state IDLE, counter 0. These take effect on the first rising edge with rst=1.
- rst mid-run: run is discarded; next cycle matches the reset values.
- start accepted at edge k -> busy=1, y=0 visible after edge k.
- Sample accepted at edge k -> updated y visible after edge k (1-cycle latency).
- Last sample accepted at edge k:
  - After edge k: done=1, busy=0, y final.
  - After edge k+1: done=0.
- Minimum run length = N_ITER cycles of RUN plus 1 cycle of DONE. Back-to-back runs are possible by asserting start during DONE.
- N_ITER=1: a single accepted sample moves the block to DONE.

## Configuration
- ABS_ACC_SAT_EN defined: on carry-out, y saturates to 2^ACC_W-1 and stays there for the rest of the run; overflow is set.
- ABS_ACC_SAT_EN undefined: on carry-out, y wraps modulo 2^ACC_W; overflow is set.
- Neither setting changes done/busy timing.

## Test plan
- Defaults, start, then 99 samples x=1 with en=1 -> done pulse one cycle after the 99th sample, y=99, overflow=0.
- Defaults, alternate x=5 and x=-5 (0xFFFFFFFB) for 99 samples -> y=495.
- Defaults, en toggling 1-0-1 with x=-7 on every cycle -> y advances only on en=1 cycles; final y=693; done not early.
- DATA_W=8, ACC_W=8, N_ITER=3, x=-128 three times:
  - With ABS_ACC_SAT_EN: y=255, overflow=1.
  - Without ABS_ACC_SAT_EN: y=128 (384 mod 256), overflow=1.
  - Both cases: a new start clears y and overflow to 0.
- rst asserted after 50 samples -> next cycle y=0, busy=0, done=0. A fresh start plus 99 samples of x=2 -> y=198.
- start held high throughout a run -> ignored while busy. start during DONE begins a new run: y=0 on the next cycle and busy=1.

Source files
------------

// File: rtl/abs_accumulator.sv
// abs_accumulator
//   Sums |x| over N_ITER accepted samples into an ACC_W-bit accumulator,
//   using a start/done handshake and a per-cycle sample enable.
//   Configuration macro: ABS_ACC_SAT_EN. When it is defined, a carry-out
//   saturates y to all-ones. When it is undefined, y wraps. In both builds
//   a carry-out sets the sticky overflow flag.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    begin a run (honoured in IDLE or DONE only)
//   en       sample valid during RUN
//   x        DATA_W two's-complement sample
//   y        ACC_W registered accumulator / result
//   busy     high while in RUN
//   done     one-cycle pulse after the last sample is accepted
//   overflow sticky carry-out flag, cleared by an accepted start or rst
module abs_accumulator #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int N_ITER = 99
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic [DATA_W-1:0] x,
  output logic [ACC_W-1:0]  y,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int CNT_W = $clog2(N_ITER + 1);
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mag;
  logic [SUM_W-1:0]  sum;
  logic              accept, last, clear;

  // Negation is done at DATA_W bits and the result is treated as unsigned.
  // For the most-negative input this gives exactly 2^(DATA_W-1).
  assign mag    = x[DATA_W-1] ? (~x + DATA_W'(1)) : x;
  assign sum    = {1'b0, y} + SUM_W'(mag);
  assign accept = (state == RUN) && en;
  assign last   = (cnt == CNT_W'(N_ITER - 1));
  assign clear  = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (accept && last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      y        <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        y        <= '0;
        cnt      <= '0;
        overflow <= 1'b0;
      end else if (accept) begin
        cnt <= cnt + CNT_W'(1);
        if (sum[ACC_W]) overflow <= 1'b1;
`ifdef ABS_ACC_SAT_EN
        // Once y is pinned at all-ones, any further non-zero add carries
        // again, so y stays saturated for the rest of the run.
        y <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
        y <= sum[ACC_W-1:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_abs_accumulator.sv
// Bench for abs_accumulator. It drives a default instance (32/32/99) and a
// small 8/8/3 instance. Expected run results are queued when the final
// sample is driven and popped when done is seen.
module tb_abs_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, en;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy, done, overflow;
  logic        start_s, en_s;
  logic [7:0]  x_s, y_s;
  logic        busy_s, done_s, ovf_s;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] y;
    bit          ov;
  } res_t;

  typedef struct {
    logic [31:0] xval;
    bit          alt;     // alternate sign of x on each accepted sample
    bit          en_tog;  // en toggles 1-0-1 on every cycle
    logic [31:0] exp_y;
    bit          exp_ov;
  } vec_t;

  res_t q_d[$];
  res_t q_s[$];
  vec_t tbl[6];

  abs_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .x(x),
    .y(y), .busy(busy), .done(done), .overflow(overflow)
  );

  abs_accumulator #(.DATA_W(8), .ACC_W(8), .N_ITER(3)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .en(en_s), .x(x_s),
    .y(y_s), .busy(busy_s), .done(done_s), .overflow(ovf_s)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // scoreboard monitors
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q_d.size() == 0) chk("sb_dflt_unexpected_done", 1, 0);
      else begin
        res_t r;
        r = q_d.pop_front();
        chk("sb_dflt_y", 64'(y), r.y);
        chk("sb_dflt_ovf", 64'(overflow), 64'(r.ov));
      end
    end
    if (!rst && done_s) begin
      if (q_s.size() == 0) chk("sb_small_unexpected_done", 1, 0);
      else begin
        res_t r;
        r = q_s.pop_front();
        chk("sb_small_y", 64'(y_s), r.y);
        chk("sb_small_ovf", 64'(ovf_s), 64'(r.ov));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One full run on the default instance. The bench keeps its own model
  // and compares it with y after every cycle. The table constant goes to
  // the scoreboard.
  task automatic run_vec(input vec_t v, input bit hold_start);
    longint model, sx, mag;
    bit     ov;
    int     acc_n, cyc;
    bit     e;
    logic [31:0] xs;
    start = 1'b1; en = 1'b0;
    @(negedge clk);
    chk("start_busy", 64'(busy), 1);
    chk("start_y_clear", 64'(y), 0);
    chk("start_ovf_clear", 64'(overflow), 0);
    start = hold_start;
    model = 0; ov = 0; acc_n = 0; cyc = 0;
    while (acc_n < 99 && cyc < 1000) begin
      e  = v.en_tog ? (cyc % 2 == 0) : 1'b1;
      xs = (v.alt && (acc_n % 2 == 1)) ? -v.xval : v.xval;
      en = e; x = xs;
      if (e) begin
        sx    = longint'($signed(xs));
        mag   = (sx < 0) ? -sx : sx;
        model = model + mag;
        if (model > 64'hFFFF_FFFF) begin
          ov = 1;
`ifdef ABS_ACC_SAT_EN
          model = 64'hFFFF_FFFF;
`else
          model = model & 64'hFFFF_FFFF;
`endif
        end
        acc_n++;
        if (acc_n == 99) q_d.push_back('{y: 64'(v.exp_y), ov: v.exp_ov});
      end
      @(negedge clk);
      cyc++;
      if (acc_n < 99) begin
        if (busy !== 1'b1 || done !== 1'b0) chk("run_busy_done", {busy, done}, 2'b10);
        if (64'(y) !== model) chk("run_y_track", 64'(y), model);
      end
    end
    if (cyc >= 1000) chk("run_timeout", 1, 0);
    en = 1'b0;
    chk("done_pulse", 64'(done), 1);
    chk("done_busy_low", 64'(busy), 0);
    chk("model_vs_table", model, 64'(v.exp_y));
    chk("model_ovf_vs_table", 64'(ov), 64'(v.exp_ov));
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 0);
    if (hold_start) begin
      chk("done_restart_busy", 64'(busy), 1);
      chk("done_restart_y", 64'(y), 0);
    end else begin
      chk("idle_busy", 64'(busy), 0);
      chk("idle_y_hold", 64'(y), 64'(v.exp_y));
      chk("idle_ovf_hold", 64'(overflow), 64'(v.exp_ov));
    end
  endtask

  initial begin
`ifdef ABS_ACC_SAT_EN
    tbl[0] = '{32'h8000_0000, 0, 0, 32'hFFFF_FFFF, 1};
    tbl[2] = '{32'h7FFF_FFFF, 0, 0, 32'hFFFF_FFFF, 1};
`else
    tbl[0] = '{32'h8000_0000, 0, 0, 32'h8000_0000, 1};
    tbl[2] = '{32'h7FFF_FFFF, 0, 0, 32'h7FFF_FF9D, 1};
`endif
    tbl[1] = '{32'd1,         0, 0, 32'd99,  0};
    tbl[3] = '{32'd5,         1, 0, 32'd495, 0};
    tbl[4] = '{32'hFFFF_FFF9, 0, 1, 32'd693, 0};
    tbl[5] = '{32'd2,         0, 0, 32'd198, 0};

    rst = 1'b1; start = 0; en = 0; x = 0; start_s = 0; en_s = 0; x_s = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_y", 64'(y), 0);
    chk("rst_flags", {busy, done, overflow}, 0);
    chk("rst_small", {y_s, busy_s, done_s, ovf_s}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_start", {busy, done}, 0);

    for (int i = 0; i < 5; i++) run_vec(tbl[i], 1'b0);

    // reset in the middle of a run
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; en = 1'b1; x = 32'd3;
    repeat (50) @(negedge clk);
    chk("mid_y_50", 64'(y), 150);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    chk("midrst_y", 64'(y), 0);
    chk("midrst_flags", {busy, done, overflow}, 0);
    rst = 1'b0;
    @(negedge clk);
    run_vec(tbl[5], 1'b0);

    // start held high across a run, then a restart from DONE
    run_vec(tbl[1], 1'b1);
    start = 1'b0; en = 1'b1; x = 32'd0;
    for (int i = 0; i < 99; i++) begin
      if (i == 98) q_d.push_back('{y: 64'd0, ov: 1'b0});
      @(negedge clk);
    end
    en = 1'b0;
    chk("restart_run_done", 64'(done), 1);
    @(negedge clk);

    // small instance: -128 three times
    start_s = 1'b1;
    @(negedge clk);
    chk("small_start_busy", 64'(busy_s), 1);
    start_s = 1'b0; en_s = 1'b1; x_s = 8'h80;
`ifdef ABS_ACC_SAT_EN
    q_s.push_back('{y: 64'd255, ov: 1'b1});
`else
    q_s.push_back('{y: 64'd128, ov: 1'b1});
`endif
    @(negedge clk);
    chk("small_y1", 64'(y_s), 128);
    @(negedge clk);
    chk("small_ovf_set", 64'(ovf_s), 1);
    @(negedge clk);
    en_s = 1'b0;
    chk("small_done", 64'(done_s), 1);
    @(negedge clk);
    chk("small_idle_ovf_hold", 64'(ovf_s), 1);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    chk("small_restart_clear", {y_s, ovf_s, busy_s}, 10'b1);
    en_s = 1'b1; x_s = 8'h01;
    q_s.push_back('{y: 64'd3, ov: 1'b0});
    repeat (3) @(negedge clk);
    en_s = 1'b0;
    chk("small_done2", 64'(done_s), 1);
    @(negedge clk);

    chk("sb_dflt_drained", 64'(q_d.size()), 0);
    chk("sb_small_drained", 64'(q_s.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
